// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: mult/div sequencer states,
// pipeline stage indices and the default mult/div latency.
package pipe_pkg;

  localparam int MD_CYCLES_DEF = 32;
  localparam int NUM_STAGES    = 5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic [2:0] {
    STG_F = 3'd0,
    STG_D = 3'd1,
    STG_E = 3'd2,
    STG_M = 3'd3,
    STG_W = 3'd4
  } stage_t;

  // A stall in stage X must also hold every earlier stage.
  function automatic logic [NUM_STAGES-1:0] stall_upto(input stage_t last);
    logic [NUM_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i <= int'(last)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Sequences the iterative mult/div unit beside EX: start pulse, run count,
// and a single HI/LO write pulse that waits out any data-memory stall.
module md_sequencer
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_md_start,
  input  logic i_dmem_busy,
  output logic o_md_go,
  output logic o_md_done,
  output logic o_md_busy,
  output logic o_md_stall
);

  // r_cnt holds the RUN cycles still to go including the current one, so
  // the op spends 1 (IDLE) + MD_CYCLES-2 (RUN) + 1 (DONE) cycles in EX.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  md_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_md_start && !i_dmem_busy) begin
          w_cnt_next   = CNT_LOAD;
          w_state_next = (MD_CYCLES == 2) ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        if (!i_dmem_busy) begin
          w_cnt_next = r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) w_state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        if (!i_dmem_busy) w_state_next = MD_IDLE;
      end
      default: w_state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    o_md_go    = 1'b0;
    o_md_done  = 1'b0;
    o_md_busy  = 1'b0;
    o_md_stall = 1'b0;
    if (!rst) begin
      case (r_state)
        MD_IDLE: begin
          o_md_stall = i_md_start;
          o_md_go    = i_md_start && !i_dmem_busy;
        end
        MD_RUN: begin
          o_md_stall = 1'b1;
          o_md_busy  = 1'b1;
        end
        // md_stall drops here so the op leaves EX and cannot retrigger.
        MD_DONE: o_md_done = !i_dmem_busy;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges memory,
// mult/div, hazard and fetch stalls plus branch redirects into stage controls.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic hazard_stall,
  input  logic redirect_d,
  input  logic if_valid,
  input  logic dmem_busy,
  input  logic md_start_e,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushM,
  output logic FlushW,
  output logic md_go,
  output logic md_done,
  output logic md_busy
);

  logic                  w_md_stall;
  logic                  w_kill_hit;
  logic [NUM_STAGES-1:0] w_stall;
  logic [NUM_STAGES-1:0] w_flush_req;
  logic [NUM_STAGES-1:0] w_flush;
  logic                  r_kill_pend;

  md_sequencer #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk        (clk),
    .rst        (rst),
    .i_md_start (md_start_e),
    .i_dmem_busy(dmem_busy),
    .o_md_go    (md_go),
    .o_md_done  (md_done),
    .o_md_busy  (md_busy),
    .o_md_stall (w_md_stall)
  );

  assign w_kill_hit = r_kill_pend && if_valid;

  always_comb begin
    w_stall = '0;
    if (dmem_busy)         w_stall = stall_upto(STG_M);
    else if (w_md_stall)   w_stall = stall_upto(STG_E);
    else if (hazard_stall) w_stall = stall_upto(STG_D);
    else if (!if_valid)    w_stall = stall_upto(STG_F);

    w_flush_req        = '0;
    w_flush_req[STG_W] = dmem_busy;
    w_flush_req[STG_M] = w_md_stall;
    w_flush_req[STG_E] = hazard_stall;
    w_flush_req[STG_D] = !if_valid || redirect_d || w_kill_hit;

    // A stage that is being held keeps its contents; its flush is dropped.
    w_flush = w_flush_req & ~w_stall;
  end

  // A redirect taken while the wrong-path fetch is still outstanding must
  // also discard that instruction when it finally arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill_pend <= 1'b0;
    end else if (!w_stall[STG_D]) begin
      if (redirect_d && !if_valid) r_kill_pend <= 1'b1;
      else if (w_kill_hit)         r_kill_pend <= 1'b0;
    end
  end

  always_comb begin
    StallF = !rst && w_stall[STG_F];
    StallD = !rst && w_stall[STG_D];
    StallE = !rst && w_stall[STG_E];
    StallM = !rst && w_stall[STG_M];
    FlushD = rst || w_flush[STG_D];
    FlushE = rst || w_flush[STG_E];
    FlushM = rst || w_flush[STG_M];
    FlushW = rst || w_flush[STG_W];
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int MDC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_stall = 1'b0;
  logic redirect_d = 1'b0;
  logic if_valid = 1'b1;
  logic dmem_busy = 1'b0;
  logic md_start_e = 1'b0;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushM, FlushW;
  logic md_go, md_done, md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(.MD_CYCLES(MDC), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard_stall(hazard_stall),
    .redirect_d  (redirect_d),
    .if_valid    (if_valid),
    .dmem_busy   (dmem_busy),
    .md_start_e  (md_start_e),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .FlushW      (FlushW),
    .md_go       (md_go),
    .md_done     (md_done),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  // Output vector layout: Stall F,D,E,M | Flush D,E,M,W | go,done,busy
  logic [10:0] dut_vec;
  assign dut_vec = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                    md_go, md_done, md_busy};

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: m_prog = how many cycles the current mult/div op has
  // already spent in EX (0 = no op); m_kill = wrong-path fetch outstanding.
  int          m_prog = 0;
  logic        m_kill = 1'b0;
  int          lvl;
  logic        m_mdstall, m_go, m_done, m_mbusy;
  logic [4:0]  st, fl;
  logic [10:0] exp_vec;

  always @(negedge clk) begin
    m_mdstall = (m_prog == 0 && md_start_e) || (m_prog > 0 && m_prog < MDC - 1);
    m_go      = (m_prog == 0) && md_start_e && !dmem_busy;
    m_done    = (m_prog == MDC - 1) && !dmem_busy;
    m_mbusy   = (m_prog > 0) && (m_prog < MDC - 1);

    lvl = dmem_busy ? 4 : m_mdstall ? 3 : hazard_stall ? 2 : !if_valid ? 1 : 0;
    for (int s = 0; s < 5; s++) st[s] = (s < lvl);
    fl[0] = 1'b0;
    fl[1] = !if_valid || redirect_d || (m_kill && if_valid);
    fl[2] = hazard_stall;
    fl[3] = m_mdstall;
    fl[4] = dmem_busy;
    fl = fl & ~st;

    if (rst) exp_vec = 11'b0000_1111_000;
    else     exp_vec = {st[0], st[1], st[2], st[3], fl[1], fl[2], fl[3], fl[4],
                        m_go, m_done, m_mbusy};
    check("model", dut_vec, exp_vec);

    if (rst) begin
      m_prog = 0;
      m_kill = 1'b0;
    end else begin
      if (m_prog == 0) begin
        if (m_go) m_prog = 1;
      end else if (m_prog < MDC - 1) begin
        if (!dmem_busy) m_prog++;
      end else if (!dmem_busy) begin
        m_prog = 0;
      end
      if (!st[1]) begin
        if (redirect_d && !if_valid)   m_kill = 1'b1;
        else if (m_kill && if_valid)   m_kill = 1'b0;
      end
    end
  end

  task automatic set_in(input logic r, input logic hz, input logic rd,
                        input logic iv, input logic db, input logic ms);
    rst = r; hazard_stall = hz; redirect_d = rd;
    if_valid = iv; dmem_busy = db; md_start_e = ms;
  endtask

  // Check the current cycle against a literal, then advance one cycle.
  task automatic lit(input string name, input logic [10:0] exp);
    #1;
    check(name, dut_vec, exp);
    @(posedge clk);
    #1;
  endtask

  int   ms_hold = 0;
  logic r_ms = 1'b0;

  initial begin
    set_in(1, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 11'b0000_1111_000);

    set_in(0, 1, 0, 1, 0, 0); lit("lw_use", 11'b1100_0100_000);
    set_in(0, 0, 0, 1, 0, 0); lit("idle", 11'b0000_0000_000);

    set_in(0, 0, 0, 1, 0, 1); lit("md_c0_go", 11'b1110_0010_100);
    lit("md_c1_run", 11'b1110_0010_001);
    lit("md_c2_run", 11'b1110_0010_001);
    lit("md_c3_done", 11'b0000_0000_010);
    set_in(0, 0, 0, 1, 0, 0); lit("md_after", 11'b0000_0000_000);

    set_in(0, 0, 0, 1, 0, 1); lit("mdb_c0", 11'b1110_0010_100);
    lit("mdb_c1", 11'b1110_0010_001);
    set_in(0, 0, 0, 1, 1, 1); lit("mdb_busy_c2", 11'b1111_0001_001);
    lit("mdb_busy_c3", 11'b1111_0001_001);
    lit("mdb_busy_c4", 11'b1111_0001_001);
    set_in(0, 0, 0, 1, 0, 1); lit("mdb_c5_run", 11'b1110_0010_001);
    lit("mdb_c6_done", 11'b0000_0000_010);
    set_in(0, 0, 0, 1, 0, 0); lit("mdb_after", 11'b0000_0000_000);

    set_in(0, 0, 0, 1, 0, 1); lit("mdd_c0", 11'b1110_0010_100);
    lit("mdd_c1", 11'b1110_0010_001);
    lit("mdd_c2", 11'b1110_0010_001);
    set_in(0, 0, 0, 1, 1, 1); lit("mdd_hold_c3", 11'b1111_0001_000);
    lit("mdd_hold_c4", 11'b1111_0001_000);
    set_in(0, 0, 0, 1, 0, 1); lit("mdd_done_c5", 11'b0000_0000_010);
    set_in(0, 0, 0, 1, 0, 0); lit("mdd_after", 11'b0000_0000_000);

    set_in(0, 0, 1, 0, 0, 0); lit("redir_c0", 11'b1000_1000_000);
    set_in(0, 0, 0, 0, 0, 0); lit("redir_c1", 11'b1000_1000_000);
    lit("redir_c2", 11'b1000_1000_000);
    set_in(0, 0, 0, 1, 0, 0); lit("redir_kill", 11'b0000_1000_000);
    lit("redir_clear", 11'b0000_0000_000);

    set_in(0, 1, 1, 1, 1, 0); lit("mem_hz_redir", 11'b1111_0001_000);
    set_in(0, 0, 0, 1, 0, 0); lit("idle2", 11'b0000_0000_000);

    set_in(0, 0, 0, 1, 0, 1); lit("rst_c0", 11'b1110_0010_100);
    lit("rst_c1", 11'b1110_0010_001);
    set_in(1, 0, 0, 1, 0, 1); lit("rst_mid", 11'b0000_1111_000);
    set_in(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) lit("rst_no_done", 11'b0000_0000_000);

    for (int i = 0; i < 4000; i++) begin
      if (ms_hold > 0) begin
        ms_hold--;
      end else begin
        r_ms    = ($urandom_range(0, 2) == 0);
        ms_hold = $urandom_range(0, 8);
      end
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) == 0, r_ms);
      @(posedge clk);
      #1;
    end

    set_in(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It merges the hazard detector's stall request, instruction-memory wait, data-memory wait and branch/jump redirect into per-stage Stall/Flush controls. It also sequences the iterative mult/div unit that sits beside the EX stage, holding the pipeline while that unit runs. It sits between the hazard detector, the memory interfaces and all pipeline registers.

Parameters:
MD_CYCLES, 32, EX-stage occupancy of a mult/div op in cycles (>=2)
CNT_W, 6, width of mult/div down-counter; must satisfy 2**CNT_W > MD_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
hazard_stall  in  1  lw-use or branch-operand stall from hazard detector (stall F,D; bubble E)
redirect_d  in  1  taken branch or jump resolved in ID (PCSrcD|JumpD)
if_valid  in  1  instruction memory returns the instruction for the current PC this cycle
dmem_busy  in  1  data memory has not finished the M-stage access
md_start_e  in  1  EX-stage instruction is mult/multu/div/divu
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  clear EX/MEM
FlushW  out  1  clear MEM/WB
md_go  out  1  one-cycle pulse: mult/div unit latches operands
md_done  out  1  one-cycle pulse: HI/LO write enable
md_busy  out  1  state is MD_RUN

Behaviour:
- While rst=1: all Stall*=0, all Flush*=1, md_go=md_done=md_busy=0. FSM returns to MD_IDLE, counter to 0 and kill_pend to 0 on the next edge. Reset mid-operation abandons the mult/div op and no md_done is issued.
- Stall sources, highest priority first:
  1. mem_stall = dmem_busy: StallF,D,E,M=1, FlushW=1.
  2. md_stall: StallF,D,E=1, FlushM=1.
  3. hazard_stall: StallF,D=1, FlushE=1.
  4. fetch_stall = !if_valid: StallF=1, FlushD=1.
- Each stall source also asserts every Stall of earlier stages. A Flush of stage X is suppressed if StallX is asserted by any source in the same cycle.
- md_stall is defined as (state==MD_IDLE & md_start_e) | state==MD_RUN.
- Mult/div FSM:
  - MD_IDLE: if md_start_e & !dmem_busy, pulse md_go, load cnt=MD_CYCLES-2 and go to MD_RUN.
  - MD_RUN: decrement cnt while !dmem_busy. When cnt==0 and !dmem_busy, go to MD_DONE.
  - MD_DONE: md_done=1 for exactly one cycle and md_stall=0, so the op advances to M. If dmem_busy, hold MD_DONE with md_done=0 until the cycle dmem_busy=0, then pulse and go to MD_IDLE. This prevents a re-trigger by the same op.
  - Result: with no dmem_busy, a mult/div instruction occupies E for exactly MD_CYCLES cycles.
- Redirect/fetch kill:
  - If redirect_d=1 and StallD=0: FlushD=1, overriding the fetch rule.
  - If additionally !if_valid, set kill_pend=1. The wrong-path fetch is still outstanding.
  - While kill_pend=1, the cycle if_valid=1 forces FlushD=1 (when StallD=0) and clears kill_pend.
  - redirect_d while StallD=1 is ignored, because the branch is re-evaluated next cycle.
- Simultaneous events:
  - dmem_busy with hazard_stall: only the mem_stall pattern applies. FlushE is suppressed because StallE=1.
  - md_stall with redirect_d cannot flush D (StallD=1).
- All outputs are combinational from state plus inputs; state is registered. No combinational path from Stall*/Flush* back to any input.

Decomposition:
- Shared package pipe_pkg holds:
  - the FSM state encoding md_state_t {MD_IDLE, MD_RUN, MD_DONE}, 2-bit;
  - MD_CYCLES_DEF;
  - a stage-index enum F,D,E,M,W.
- One natural sub-module, md_sequencer, containing the FSM and counter with outputs md_go/md_done/md_busy/md_stall. The stall-priority merge stays in pipeline_ctrl.

Test Plan:
- lw-use: hazard_stall=1 for 1 cycle, if_valid=1 -> StallF=StallD=1, FlushE=1, all other outputs 0.
- MD_CYCLES=4, md_start_e=1 held → md_go at cycle 0; StallE=1 at cycles 0-2; md_done=1 at cycle 3 with StallE=0; FlushM=1 at cycles 0-2; md_busy=1 at cycles 1-2.
- Mult/div with dmem_busy=1 during cycles 3-5 of the op → counter frozen, md_done delayed to the first cycle with dmem_busy=0, single pulse, FlushW=1 while busy.
- redirect_d=1, if_valid=0 for 3 cycles then 1 → FlushD=1 at cycle 0 and again on the if_valid cycle; kill_pend clears; later if_valid cycles give FlushD=0.
- dmem_busy=1 with hazard_stall=1 and redirect_d=1 → StallF,D,E,M=1, FlushW=1, FlushD=FlushE=0.
- rst=1 at MD_RUN cycle 2 → Flush*=1, Stall*=0 during reset; after release md_busy=0 and no md_done pulse ever appears.
